// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - ssub_state_e : controller states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH: default operand/result width
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ssub_state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   Combinational 1-bit full-subtractor cell: computes x - y - bin.
//   Ports:
//     x    in  1  minuend bit
//     y    in  1  subtrahend bit
//     bin  in  1  borrow in
//     d    out 1  difference bit
//     bout out 1  borrow out
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // A borrow is generated when x=0,y=1, and propagated when x==y.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b, one bit per clock, LSB
//   first, built from one full_subtractor cell and a registered borrow.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN
//     defined   -> adds the 'overflow' output (signed overflow, registered
//                  with diff) and the operand sign-capture flops.
//     undefined -> no overflow port, no sign flops; otherwise identical.
//
//   Ports:
//     clk        in   1      system clock, rising edge
//     reset_n    in   1      asynchronous active-low reset
//     start      in   1      request; sampled only in IDLE or DONE
//     a          in   WIDTH  minuend, captured on accepted start
//     b          in   WIDTH  subtrahend, captured on accepted start
//     busy       out  1      high during the WIDTH RUN cycles
//     done       out  1      one-cycle pulse, result valid
//     diff       out  WIDTH  a - b mod 2^WIDTH, held until next done
//     borrow_out out  1      1 iff a < b (unsigned), held with diff
//     overflow   out  1      (SERIAL_SUB_OVF_EN only) signed overflow
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    ssub_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             ovf_q, ovf_d;
`endif

    logic fs_d;
    logic fs_bout;
    logic accept;
    logic last_bit;

    full_subtractor u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // A new operation is only taken when the datapath is idle or just
    // finished; start during RUN is dropped, not queued.
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (count_q == CW'(WIDTH - 1));

    // NOTE: combinational logic uses blocking '=' and assigns every *_d a
    // default first, so no path leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        r_d          = r_q;
        borrow_d     = borrow_q;
        count_d      = count_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        a_sign_d     = a_sign_q;
        b_sign_d     = b_sign_q;
        ovf_d        = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                r_d      = {fs_d, r_q[WIDTH-1:1]};
                borrow_d = fs_bout;
                count_d  = count_q + CW'(1);
                if (last_bit) begin
                    state_d      = DONE;
                    // The MSB result bit is still in flight, so publish the
                    // shifted value rather than r_q.
                    diff_d       = {fs_d, r_q[WIDTH-1:1]};
                    borrow_out_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d        = (a_sign_q != b_sign_q) && (fs_d != a_sign_q);
`endif
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand load overrides the shift; diff/borrow_out keep their old
        // values until the new result completes.
        if (accept) begin
            a_sr_d   = a;
            b_sr_d   = b;
            borrow_d = 1'b0;
            count_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_d = a[WIDTH-1];
            b_sign_d = b[WIDTH-1];
`endif
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            r_q          <= '0;
            borrow_q     <= 1'b0;
            count_q      <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q     <= 1'b0;
            b_sign_q     <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            r_q          <= r_d;
            borrow_q     <= borrow_d;
            count_q      <= count_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q     <= a_sign_d;
            b_sign_q     <= b_sign_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    // DONE always lasts exactly one cycle, so its decode is the done pulse.
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow   = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). Expected results are
//   queued when an operation is launched and compared when done pulses.
//   Honours SERIAL_SUB_OVF_EN for the overflow output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W = 8;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic [W-1:0] a       = '0;
    logic [W-1:0] b       = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bo;
        logic         ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W-1:0] dd;
        dd     = x - y;
        e.diff = dd;
        e.bo   = (x < y);
        e.ovf  = (x[W-1] != y[W-1]) && (dd[W-1] != x[W-1]);
        return e;
    endfunction

    // Output monitor: compares each done against the oldest queued result.
    always @(negedge clk) begin
        if (reset_n) begin
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done) begin
                done_cnt++;
                check("pending_on_done", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_diff", {24'd0, diff}, {24'd0, mon_e.diff});
                    check("sb_borrow", {31'd0, borrow_out}, {31'd0, mon_e.bo});
`ifdef SERIAL_SUB_OVF_EN
                    check("sb_ovf", {31'd0, overflow}, {31'd0, mon_e.ovf});
`endif
                end
            end
        end
    end

    // Call just after a negedge when the DUT is in IDLE or DONE.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        sb_q.push_back(model(x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges until done (bounded), and how many of them saw busy.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end while (!done && n < 30);
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_diff"}, {24'd0, diff}, 32'd0);
        check({tag, "_bo"}, {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, d0;
        logic [W-1:0] x, y;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // 200 - 55: 8 busy cycles, done on cycle 9
        launch(8'd200, 8'd55);
        wait_done(n, nb);
        check("t1_busy_cycles", n > 0 ? nb : 0, 32'd8);
        check("t1_latency", n, 32'd9);
        check("t1_diff", {24'd0, diff}, 32'd145);
        @(negedge clk);

        // 5 - 9 wraps with borrow
        launch(8'd5, 8'd9);
        wait_done(n, nb);
        check("t2_diff", {24'd0, diff}, 32'hFC);
        check("t2_bo", {31'd0, borrow_out}, 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        @(negedge clk);
        launch(8'h80, 8'h01);
        wait_done(n, nb);
        check("t2_ovf_diff", {24'd0, diff}, 32'h7F);
        check("t2_ovf", {31'd0, overflow}, 32'd1);
`endif
        @(negedge clk);

        // Start while busy is ignored
        launch(8'd10, 8'd3);
        repeat (3) @(negedge clk);
        a = 8'd99; b = 8'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = '0; b = '0;
        wait_done(n, nb);
        check("t3_diff", {24'd0, diff}, 32'd7);
        @(negedge clk);
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        check("t3_no_second_done", done_cnt, d0);

        // Back-to-back: start held during the DONE cycle
        launch(8'd100, 8'd1);
        wait_done(n, nb);
        check("t4_diff1", {24'd0, diff}, 32'd99);
        check("t4_bo1", {31'd0, borrow_out}, 32'd0);
        launch(8'd1, 8'd2);
        check("t4_busy_after_b2b", {31'd0, busy}, 32'd1);
        check("t4_diff_held", {24'd0, diff}, 32'd99);
        wait_done(n, nb);
        check("t4_spacing", n, 32'd9);
        check("t4_diff2", {24'd0, diff}, 32'd255);
        check("t4_bo2", {31'd0, borrow_out}, 32'd1);
        @(negedge clk);

        // Reset mid-RUN
        launch(8'd50, 8'd20);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("t5_async");
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        check("t5_no_done", done_cnt, d0);
        launch(8'd50, 8'd20);
        wait_done(n, nb);
        check("t5_diff", {24'd0, diff}, 32'd30);
        @(negedge clk);

        // Edge cases
        launch(8'd77, 8'd77);
        wait_done(n, nb);
        check("eq_diff", {24'd0, diff}, 32'd0);
        check("eq_bo", {31'd0, borrow_out}, 32'd0);
        launch(8'd0, 8'd255);
        wait_done(n, nb);
        check("min_max_diff", {24'd0, diff}, 32'd1);
        check("min_max_bo", {31'd0, borrow_out}, 32'd1);

        // Streaming sweep over a spread grid (corners included), back-to-back
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 32; j++) begin
                x = W'(i * 4 + (i >> 4));
                y = W'(j * 8 + (j >> 2));
                launch(x, y);
                wait_done(n, nb);
                check("sweep_spacing", n, 32'd9);
            end
        end
        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_subtractor
